// File: rtl/serial_adder_unit_pkg.sv
// Shared constants for serial_adder_unit: FSM state encodings and counter-width helper.
package serial_adder_unit_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Ceiling log2, used to size the bit counter at elaboration time.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_unit_full_adder.sv
// Existing single-bit full adder cell used as the bit slice of serial_adder_unit.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_unit.sv
// Bit-serial WIDTH-bit adder: one operand bit pair per clock through a shared full_adder.
// Optional signed-overflow output is enabled with SERIAL_ADDER_OVF_EN.
module serial_adder_unit
  import serial_adder_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = clog2(WIDTH);
  localparam int unsigned SR_W  = WIDTH - 1;

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [SR_W-1:0]  s_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_cout;
  logic             last_bit;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last_bit = (state == S_RUN) && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_RUN;
      S_RUN:   if (last_bit) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Operand/sum shift registers, carry and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        a_sr  <= op_a;
        b_sr  <= op_b;
        carry <= cin_init;
        cnt   <= '0;
      end
    end else if (state == S_RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      s_sr  <= SR_W'({fa_s, s_sr} >> 1);
      carry <= fa_cout;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  // Result registers only move on the final bit edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      busy <= (next_state != S_IDLE);
      done <= last_bit;
      if (last_bit) begin
        sum  <= {fa_s, s_sr};
        cout <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
        ovf  <= carry ^ fa_cout;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_unit.sv
// Scoreboard bench for serial_adder_unit: driver queues arithmetic expectations, monitor checks on done.
module tb_serial_adder_unit;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin_init;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  serial_adder_unit #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .cin_init (cin_init),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               edge_no;
  } exp_t;

  exp_t             q[$];
  exp_t             mon_e;
  int               tests = 0;
  int               fails = 0;
  int               cyc = 0;
  logic [WIDTH-1:0] held_sum = '0;
  logic             held_cout = 1'b0;
  logic             prev_done = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests = tests + 1;
    if (act !== req) begin
      fails = fails + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c, input int e);
    exp_t r;
    int   ua, ub, us, sa, sb, ss;
    ua = int'(a);
    ub = int'(b);
    us = ua + ub + int'(c);
    r.sum  = WIDTH'(us % (2 ** WIDTH));
    r.cout = (us >= 2 ** WIDTH);
    sa = (ua >= 2 ** (WIDTH - 1)) ? ua - 2 ** WIDTH : ua;
    sb = (ub >= 2 ** (WIDTH - 1)) ? ub - 2 ** WIDTH : ub;
    ss = sa + sb + int'(c);
    r.ovf = (ss > 2 ** (WIDTH - 1) - 1) || (ss < -(2 ** (WIDTH - 1)));
    r.edge_no = e;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (q.size() == 0) begin
          tests = tests + 1;
          fails = fails + 1;
          $display("FAIL unexpected_done: got done with sum 0x%0h, expected no pending operation", sum);
        end else begin
          mon_e = q.pop_front();
          check("sum", 32'(sum), 32'(mon_e.sum));
          check("cout", 32'(cout), 32'(mon_e.cout));
`ifdef SERIAL_ADDER_OVF_EN
          check("ovf", 32'(ovf), 32'(mon_e.ovf));
`endif
          check("latency", 32'(cyc), 32'(mon_e.edge_no + int'(WIDTH)));
          check("busy_at_done", 32'(busy), 32'd1);
          held_sum  = mon_e.sum;
          held_cout = mon_e.cout;
        end
        check("done_single_pulse", 32'(prev_done), 32'd0);
      end else if (busy) begin
        check("hold_sum", 32'(sum), 32'(held_sum));
        check("hold_cout", 32'(cout), 32'(held_cout));
      end
      prev_done = done;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n = n + 1;
    end
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    @(negedge clk);
    wait_idle();
    op_a     = a;
    op_b     = b;
    cin_init = c;
    start    = 1'b1;
    q.push_back(model(a, b, c, cyc + 1));
    @(negedge clk);
    start    = 1'b0;
    op_a     = WIDTH'($urandom);
    op_b     = WIDTH'($urandom);
    cin_init = 1'($urandom);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'd0);
    check({tag, "_cout"}, 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
`endif
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    start    = 1'b0;
    op_a     = '0;
    op_b     = '0;
    cin_init = 1'b0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    issue(8'h0F, 8'h01, 1'b0);
    issue(8'hFF, 8'h01, 1'b0);
    issue(8'h7F, 8'h01, 1'b0);
    issue(8'h80, 8'h80, 1'b0);
    issue(8'h00, 8'h00, 1'b1);
    issue(8'hAA, 8'h55, 1'b1);

    // Start during RUN must be dropped, not queued.
    issue(8'h3C, 8'h42, 1'b0);
    repeat (2) @(negedge clk);
    op_a  = 8'hE1;
    op_b  = 8'h9D;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    issue(8'h11, 8'h22, 1'b1);

    // Reset in the middle of RUN aborts the operation.
    issue(8'h5A, 8'hC3, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_cleared("abort");
    q.delete();
    held_sum  = '0;
    held_cout = 1'b0;
    prev_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(8'h5A, 8'hC3, 1'b1);

    for (int i = 0; i < 40; i++) begin
      issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n = n + 1;
    end
    check("drain_pending", 32'(q.size()), 32'd0);
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
